// File: rtl/mac_seq_ctrl_if.sv
// Operand-stream and result-stream handshake bundle for mac_seq_ctrl.
// The master side is the operand source and result consumer. The slave side is the controller.
interface mac_seq_ctrl_if #(
    parameter int N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for a 1x1 MAC: clear, stream len operand pairs, drain, present result.
// Optional abort input is enabled by defining MAC_SEQ_CTRL_ABORT_EN.
module mac_seq_ctrl #(
    parameter int N       = 32,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1       // must be >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic [LEN_W-1:0] count,
`ifdef MAC_SEQ_CTRL_ABORT_EN
    input  logic             abort,
`endif
    mac_seq_ctrl_if.slave    io,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [N-1:0]     mac_a,
    output logic [N-1:0]     mac_b,
    input  logic [2*N-1:0]   mac_out
);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic [DW-1:0]    drain_reg, drain_next;
    logic [2*N-1:0]   res_reg, res_next;
    logic [LEN_W-1:0] count_inc;
    logic             in_ready_c;
    logic             abort_hit;

`ifdef MAC_SEQ_CTRL_ABORT_EN
    assign abort_hit = abort && ((state_reg == CLEAR) || (state_reg == STREAM) ||
                                 (state_reg == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    assign count_inc = count_reg + LEN_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            count_reg <= '0;
            drain_reg <= '0;
            res_reg   <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            count_reg <= count_next;
            drain_reg <= drain_next;
            res_reg   <= res_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        count_next = count_reg;
        drain_next = drain_reg;
        res_next   = res_reg;
        in_ready_c = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        mac_a      = '0;
        mac_b      = '0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    len_next   = len;
                    count_next = '0;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                mac_clr    = 1'b1;
                drain_next = '0;
                state_next = (len_reg == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                in_ready_c = 1'b1;
                if (io.in_valid) begin
                    mac_en     = 1'b1;
                    mac_a      = io.in_a;
                    mac_b      = io.in_b;
                    count_next = count_inc;
                    if (count_inc == len_reg) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // mac_out settles MAC_LAT edges after the last MAC edge.
                // One more cycle is spent here so it is stable for a full cycle before capture.
                if (drain_reg == DW'(MAC_LAT)) begin
                    res_next   = mac_out;
                    state_next = DONE;
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            DONE: begin
                if (io.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort discards the job but leaves count visible for inspection.
        if (abort_hit) begin
            state_next = IDLE;
            in_ready_c = 1'b0;
            mac_en     = 1'b0;
            mac_a      = '0;
            mac_b      = '0;
            count_next = count_reg;
            res_next   = res_reg;
        end
    end

    assign busy         = (state_reg != IDLE);
    assign count        = count_reg;
    assign io.in_ready  = in_ready_c;
    assign io.res_valid = (state_reg == DONE);
    assign io.res       = res_reg;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed-vector bench for mac_seq_ctrl with a behavioural MAC (accumulator plus one output stage).
module tb_mac_seq_ctrl;
    localparam int N       = 32;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic [LEN_W-1:0] count;
    logic             mac_clr;
    logic             mac_en;
    logic [N-1:0]     mac_a;
    logic [N-1:0]     mac_b;
    logic [2*N-1:0]   mac_out;
`ifdef MAC_SEQ_CTRL_ABORT_EN
    logic             abort = 1'b0;
`endif

    mac_seq_ctrl_if #(.N(N)) bus ();

    always #5 clk = ~clk;

    mac_seq_ctrl #(.N(N), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .count   (count),
`ifdef MAC_SEQ_CTRL_ABORT_EN
        .abort   (abort),
`endif
        .io      (bus),
        .mac_clr (mac_clr),
        .mac_en  (mac_en),
        .mac_a   (mac_a),
        .mac_b   (mac_b),
        .mac_out (mac_out)
    );

    // Behavioural MAC: accumulator updates on the enabled edge, visible on mac_out one edge later.
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] out_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            if (mac_clr)
                acc_q <= '0;
            else if (mac_en)
                acc_q <= acc_q + ({32'd0, mac_a} * {32'd0, mac_b});
            out_q <= acc_q;
        end
    end
    assign mac_out = out_q;

    int en_cnt = 0;
    int clr_cnt = 0;
    always @(posedge clk) begin
        if (mac_en)  en_cnt  <= en_cnt + 1;
        if (mac_clr) clr_cnt <= clr_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;
    int edges = 0;
    int lat;
    int en0, clr0;
    logic [N-1:0] pa [0:3];
    logic [N-1:0] pb [0:3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    // After return: at the negedge following the accept edge t (edges==0), FSM in CLEAR.
    task automatic start_job(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        edges = -1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid = 1'b0;
                    tick();
                end
            end
            bus.in_valid = 1'b1;
            bus.in_a     = pa[i];
            bus.in_b     = pb[i];
            begin
                int w;
                w = 0;
                #1;
                while (!bus.in_ready && w < 20) begin
                    tick();
                    #1;
                    w++;
                end
                if (w >= 20) check("feed_timeout", 64'd0, 64'd1);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
    endtask

    task automatic wait_res(output int l);
        int w;
        w = 0;
        while (!bus.res_valid && w < 40) begin
            tick();
            w++;
        end
        l = edges;
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_count", count, 0);
        rst = 1'b1;
        tick();

        // Test 1: len=3, continuous valid
        pa = '{32'd9, 32'd3, 32'd5, 32'd0};
        pb = '{32'd2, 32'd4, 32'd5, 32'd0};
        en0 = en_cnt;
        clr0 = clr_cnt;
        start_job(8'd3);
        check("t1_clear_mac_clr", mac_clr, 1);
        check("t1_clear_busy", busy, 1);
        check("t1_clear_in_ready", bus.in_ready, 0);
        feed(3, 0);
        check("t1_in_ready_drop", bus.in_ready, 0);
        wait_res(lat);
        check("t1_latency", lat, 6);
        check("t1_res", bus.res, 55);
        check("t1_count", count, 3);
        check("t1_en_pulses", en_cnt - en0, 3);
        check("t1_clr_pulses", clr_cnt - clr0, 1);
        handshake();
        check("t1_res_valid_low", bus.res_valid, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_res_retained", bus.res, 55);

        // Test 2: same job with 2-cycle gaps
        en0 = en_cnt;
        start_job(8'd3);
        feed(3, 2);
        wait_res(lat);
        check("t2_latency", lat, 10);
        check("t2_res", bus.res, 55);
        check("t2_en_pulses", en_cnt - en0, 3);
        handshake();

        // Test 3: len=0
        en0 = en_cnt;
        clr0 = clr_cnt;
        start_job(8'd0);
        wait_res(lat);
        check("t3_latency", lat, 3);
        check("t3_res", bus.res, 0);
        check("t3_en_pulses", en_cnt - en0, 0);
        check("t3_clr_pulses", clr_cnt - clr0, 1);
        check("t3_count", count, 0);
        handshake();

        // Test 4: back-pressure in DONE with start pulses ignored; 1*1 + 2*3 = 7
        pa = '{32'd1, 32'd2, 32'd0, 32'd0};
        pb = '{32'd1, 32'd3, 32'd0, 32'd0};
        start_job(8'd2);
        feed(2, 0);
        wait_res(lat);
        check("t4_latency", lat, 5);
        for (int k = 0; k < 5; k++) begin
            start = (k % 2 == 0);
            tick();
            check("t4_hold_valid", bus.res_valid, 1);
            check("t4_hold_res", bus.res, 7);
            check("t4_hold_busy", busy, 1);
        end
        start = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        start = 1'b0;
        bus.res_ready = 1'b0;
        check("t4_hs_busy", busy, 0);
        check("t4_hs_res_valid", bus.res_valid, 0);
        tick();
        check("t4_start_ignored", busy, 0);

        // Test 5: async reset after 2 of 4 pairs, then len=1 job 7*6 = 42
        pa = '{32'd1, 32'd2, 32'd3, 32'd4};
        pb = '{32'd1, 32'd2, 32'd3, 32'd4};
        start_job(8'd4);
        feed(2, 0);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'd3;
        bus.in_b     = 32'd3;
        #1;
        check("t5_pre_mac_en", mac_en, 1);
        check("t5_pre_count", count, 2);
        rst = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_in_ready", bus.in_ready, 0);
        check("t5_rst_mac_clr", mac_clr, 0);
        check("t5_rst_mac_en", mac_en, 0);
        check("t5_rst_mac_a", mac_a, 0);
        check("t5_rst_mac_b", mac_b, 0);
        check("t5_rst_res_valid", bus.res_valid, 0);
        check("t5_rst_res", bus.res, 0);
        check("t5_rst_count", count, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        rst = 1'b1;
        tick();
        pa[0] = 32'd7;
        pb[0] = 32'd6;
        start_job(8'd1);
        feed(1, 0);
        wait_res(lat);
        check("t5_latency", lat, 4);
        check("t5_res", bus.res, 42);
        handshake();

`ifdef MAC_SEQ_CTRL_ABORT_EN
        // Test 6: abort after 1 of 3 pairs
        pa = '{32'd9, 32'd3, 32'd5, 32'd0};
        pb = '{32'd2, 32'd4, 32'd5, 32'd0};
        start_job(8'd3);
        feed(1, 0);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'd3;
        bus.in_b     = 32'd4;
        abort = 1'b1;
        #1;
        check("t6_abort_in_ready", bus.in_ready, 0);
        check("t6_abort_mac_en", mac_en, 0);
        tick();
        abort = 1'b0;
        bus.in_valid = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_count", count, 1);
        check("t6_res_valid", bus.res_valid, 0);
        tick();
        check("t6_res_valid_later", bus.res_valid, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
